// File: rtl/mc_datapath_pkg.sv
// mc_datapath_pkg: shared definitions for the multi-cycle datapath.
//   - opcode constants (4-bit opcode field in the instruction MSBs)
//   - FSM state enumeration
//   - instruction field-position helpers; an instruction word is
//     {opcode[3:0], rd, rs1, rs2}, each register field RA_W bits wide.
package mc_datapath_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_NOP  = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  // Field selectors, numbered from the LSB end of the word.
  localparam int FLD_RS2 = 0;
  localparam int FLD_RS1 = 1;
  localparam int FLD_RD  = 2;
  localparam int FLD_OP  = 3;

  // Bit position of the least significant bit of a field.
  function automatic int fld_lsb(input int ra_w, input int fld);
    return fld * ra_w;
  endfunction

  // Total instruction width for a given register-address width.
  function automatic int iw_width(input int ra_w);
    return 4 + 3 * ra_w;
  endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// mc_datapath_if: control/status bundle of mc_datapath.
//   start, imem_we, imem_waddr, imem_wdata : driven by the host (master)
//   busy, done, pc, result, carry, zero,
//   illegal                                 : driven by the datapath (slave)
interface mc_datapath_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4,
  parameter int IW     = 10
);
  logic              start;
  logic              imem_we;
  logic [PC_W-1:0]   imem_waddr;
  logic [IW-1:0]     imem_wdata;
  logic              busy;
  logic              done;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              zero;
  logic              illegal;

  modport master (
    output start, imem_we, imem_waddr, imem_wdata,
    input  busy, done, pc, result, carry, zero, illegal
  );

  modport slave (
    input  start, imem_we, imem_waddr, imem_wdata,
    output busy, done, pc, result, carry, zero, illegal
  );
endinterface

// File: rtl/mc_alu.sv
// mc_alu: combinational ALU of the multi-cycle datapath.
//   op     in  4       opcode
//   a, b   in  DATA_W  operands
//   result out DATA_W  ALU result
//   carry  out 1       carry (ADD) / borrow (SUB), else 0
//   writes out 1       opcode updates result/flags/register file
//   legal  out 1       opcode is defined in this build
// Optional feature: define MC_DATAPATH_SLT_EN to enable opcode 4 (SLT);
// without it opcode 4 is reported as not legal.
module mc_alu
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              writes,
  output logic              legal
);

  logic [DATA_W:0] wide;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    writes = 1'b0;
    legal  = 1'b1;
    wide   = '0;
    case (op)
      OP_AND: begin
        result = a & b;
        writes = 1'b1;
      end
      OP_OR: begin
        result = a | b;
        writes = 1'b1;
      end
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        writes = 1'b1;
      end
      OP_SUB: begin
        // The extra MSB of a one-bit-wider difference is the unsigned borrow.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        writes = 1'b1;
      end
`ifdef MC_DATAPATH_SLT_EN
      OP_SLT: begin
        result = DATA_W'(a < b);
        writes = 1'b1;
      end
`endif
      OP_NOP: begin
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle (FETCH/DECODE/EXECUTE/WRITEBACK) register datapath.
//   clk    in  clock, all state changes on the rising edge
//   reset  in  synchronous, active-high
//   bus    mc_datapath_if.slave:
//            start, imem_we/imem_waddr/imem_wdata (in)
//            busy, done, pc, result, carry, zero, illegal (out)
// Instruction word: {opcode[3:0], rd, rs1, rs2}. Every non-HALT instruction
// takes four cycles; HALT stops after DECODE without writeback.
// Optional feature: MC_DATAPATH_SLT_EN enables the SLT opcode (see mc_alu).
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_N      = 4,
  parameter int IMEM_DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  mc_datapath_if.slave bus
);

  localparam int RA_W    = $clog2(REG_N);
  localparam int PC_W    = $clog2(IMEM_DEPTH);
  localparam int IW      = iw_width(RA_W);
  localparam int OP_LSB  = fld_lsb(RA_W, FLD_OP);
  localparam int RD_LSB  = fld_lsb(RA_W, FLD_RD);
  localparam int RS1_LSB = fld_lsb(RA_W, FLD_RS1);
  localparam int RS2_LSB = fld_lsb(RA_W, FLD_RS2);

  state_t state, state_nxt;

  logic [IW-1:0]     imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs [REG_N];

  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] op_a, op_b;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] result;
  logic              carry;
  logic              illegal;
  logic              done;
  logic              wr_en;
  logic              busy;

  logic [3:0]        opcode;
  logic [RA_W-1:0]   rd, rs1, rs2;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_writes, alu_legal;

  assign opcode = ir[OP_LSB +: 4];
  assign rd     = ir[RD_LSB +: RA_W];
  assign rs1    = ir[RS1_LSB +: RA_W];
  assign rs2    = ir[RS2_LSB +: RA_W];

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (opcode),
    .a      (op_a),
    .b      (op_b),
    .result (alu_result),
    .carry  (alu_carry),
    .writes (alu_writes),
    .legal  (alu_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: if (bus.start) state_nxt = ST_FETCH;
      ST_FETCH: begin
        busy      = 1'b1;
        state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        busy      = 1'b1;
        state_nxt = (opcode == OP_HALT) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        busy      = 1'b1;
        state_nxt = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        busy      = 1'b1;
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Host writes are only accepted while the machine is not running, so a
  // program cannot be modified underneath itself. Memory content survives reset.
  always_ff @(posedge clk) begin
    if (!reset && !busy && bus.imem_we) imem[bus.imem_waddr] <= bus.imem_wdata;
  end

  // Instruction/operand latches carry no reset; every path through the
  // FSM writes them before they are consumed.
  always_ff @(posedge clk) begin
    case (state)
      ST_FETCH:  ir <= imem[pc];
      ST_DECODE: begin
        op_a <= regs[rs1];
        op_b <= regs[rs2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      result  <= '0;
      carry   <= 1'b0;
      illegal <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      for (int i = 0; i < REG_N; i++) regs[i] <= DATA_W'(i);
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_HALT: begin
          if (bus.start) begin
            pc      <= '0;
            illegal <= 1'b0;
          end
        end
        ST_DECODE: done <= (opcode == OP_HALT);
        // ---- EXECUTE: register ALU outputs; NOP/undefined leave them alone
        ST_EXECUTE: begin
          wr_en <= alu_writes;
          if (alu_writes) begin
            result <= alu_result;
            carry  <= alu_carry;
          end
          if (!alu_legal) illegal <= 1'b1;
        end
        // ---- WRITEBACK: commit the registered result, advance pc (wraps)
        ST_WRITEBACK: begin
          if (wr_en) regs[rd] <= result;
          pc <= pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.pc      = pc;
  assign bus.result  = result;
  assign bus.carry   = carry;
  assign bus.zero    = (result == '0);
  assign bus.illegal = illegal;

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: self-checking bench for mc_datapath (default parameters).
// A behavioural model executes each instruction with plain integer arithmetic
// and the DUT outputs are compared per instruction at negedge sampling points.
// Honours MC_DATAPATH_SLT_EN the same way as the design.
module tb_mc_datapath;

  localparam int DATA_W     = 8;
  localparam int REG_N      = 4;
  localparam int IMEM_DEPTH = 16;
  localparam int RA_W       = 2;
  localparam int PC_W       = 4;
  localparam int IW         = 4 + 3 * RA_W;
  localparam longint MASK   = (64'd1 << DATA_W) - 1;

  logic clk;
  logic reset;

  mc_datapath_if #(.DATA_W(DATA_W), .PC_W(PC_W), .IW(IW)) bus ();

  mc_datapath #(.DATA_W(DATA_W), .REG_N(REG_N), .IMEM_DEPTH(IMEM_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [IW-1:0] imem_m [IMEM_DEPTH];
  longint        regs_m [REG_N];
  longint        result_m, carry_m, pc_m, ill_m;

  logic [IW-1:0] prog [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs1, input int rs2);
    return {4'(op), RA_W'(rd), RA_W'(rs1), RA_W'(rs2)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < REG_N; i++) regs_m[i] = longint'(i) & MASK;
    result_m = 0;
    carry_m  = 0;
    pc_m     = 0;
    ill_m    = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    64'(bus.busy),    64'd0);
    check({tag, "_done"},    64'(bus.done),    64'd0);
    check({tag, "_pc"},      64'(bus.pc),      64'd0);
    check({tag, "_result"},  64'(bus.result),  64'd0);
    check({tag, "_carry"},   64'(bus.carry),   64'd0);
    check({tag, "_zero"},    64'(bus.zero),    64'd1);
    check({tag, "_illegal"}, 64'(bus.illegal), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.imem_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_outputs("reset");
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      @(negedge clk);
      bus.imem_we    = 1'b1;
      bus.imem_waddr = PC_W'(i);
      bus.imem_wdata = prog[i];
      imem_m[i]      = prog[i];
    end
    @(negedge clk);
    bus.imem_we = 1'b0;
  endtask

  // Runs up to max_instr instructions, checking every instruction boundary.
  // With poke set, imem_we (HALT into address 0) and start are held high for
  // the whole first instruction; the model assumes both are ignored.
  task automatic run_prog(input bit do_start, input bit poke, input int max_instr,
                          output bit halted);
    logic [IW-1:0] w;
    int op, rd, rs1, rs2;
    longint a, b, r, c;
    bit wr;
    halted = 1'b0;
    if (do_start) begin
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      pc_m  = 0;
      ill_m = 0;
      check("start_busy",    64'(bus.busy),    64'd1);
      check("start_pc",      64'(bus.pc),      64'd0);
      check("start_illegal", 64'(bus.illegal), 64'd0);
    end
    for (int k = 0; k < max_instr; k++) begin
      w   = imem_m[pc_m];
      op  = int'(w[IW-1 -: 4]);
      rd  = int'(w[2*RA_W +: RA_W]);
      rs1 = int'(w[RA_W +: RA_W]);
      rs2 = int'(w[0 +: RA_W]);
      if (op == 15) begin
        @(negedge clk);
        check("halt_decode_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        check("halt_done", 64'(bus.done), 64'd1);
        check("halt_busy", 64'(bus.busy), 64'd0);
        check("halt_pc",   64'(bus.pc),   64'(pc_m));
        @(negedge clk);
        check("done_pulse", 64'(bus.done), 64'd0);
        halted = 1'b1;
        return;
      end
      if (poke && k == 0) begin
        bus.imem_we    = 1'b1;
        bus.imem_waddr = '0;
        bus.imem_wdata = enc(15, 0, 0, 0);
        bus.start      = 1'b1;
      end
      a  = regs_m[rs1];
      b  = regs_m[rs2];
      r  = 0;
      c  = 0;
      wr = 1'b0;
      case (op)
        0: begin r = a & b; wr = 1'b1; end
        1: begin r = a | b; wr = 1'b1; end
        2: begin r = (a + b) & MASK; c = (a + b) >> DATA_W; wr = 1'b1; end
        3: begin r = (a - b) & MASK; c = (a < b) ? 1 : 0; wr = 1'b1; end
`ifdef MC_DATAPATH_SLT_EN
        4: begin r = (a < b) ? 1 : 0; wr = 1'b1; end
`endif
        5: ;
        default: ill_m = 1;
      endcase
      if (wr) begin
        regs_m[rd] = r;
        result_m   = r;
        carry_m    = c;
      end
      repeat (3) @(negedge clk);
      check("exec_pc",      64'(bus.pc),      64'(pc_m));
      check("exec_result",  64'(bus.result),  64'(result_m));
      check("exec_carry",   64'(bus.carry),   64'(carry_m));
      check("exec_zero",    64'(bus.zero),    (result_m == 0) ? 64'd1 : 64'd0);
      check("exec_illegal", 64'(bus.illegal), 64'(ill_m));
      check("exec_done",    64'(bus.done),    64'd0);
      @(negedge clk);
      if (poke && k == 0) begin
        bus.imem_we = 1'b0;
        bus.start   = 1'b0;
      end
      pc_m = (pc_m + 1) % IMEM_DEPTH;
      check("wb_pc",   64'(bus.pc),   64'(pc_m));
      check("wb_busy", 64'(bus.busy), 64'd1);
    end
  endtask

  initial begin
    bit h;
    int len;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    for (int i = 0; i < IMEM_DEPTH; i++) imem_m[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_reset_outputs("por");

    // ADD r3,r3,r2 ; HALT  -> 3 + 2 = 5
    prog.delete();
    prog.push_back(enc(2, 3, 3, 2));
    prog.push_back(enc(15, 0, 0, 0));
    load_prog();
    run_prog(1'b1, 1'b0, 4, h);
    check("add_halted", 64'(h), 64'd1);
    check("add_result", 64'(bus.result), 64'h05);
    check("add_carry",  64'(bus.carry),  64'd0);
    check("add_zero",   64'(bus.zero),   64'd0);

    // SUB r0,r0,r1 -> 0 - 1 = 0xFF with borrow
    do_reset();
    prog.delete();
    prog.push_back(enc(3, 0, 0, 1));
    prog.push_back(enc(15, 0, 0, 0));
    load_prog();
    run_prog(1'b1, 1'b0, 4, h);
    check("sub_result", 64'(bus.result), 64'hFF);
    check("sub_carry",  64'(bus.carry),  64'd1);
    check("sub_zero",   64'(bus.zero),   64'd0);

    // AND r1,r0,r0 with r0 = 0 -> zero
    do_reset();
    prog.delete();
    prog.push_back(enc(0, 1, 0, 0));
    prog.push_back(enc(15, 0, 0, 0));
    load_prog();
    run_prog(1'b1, 1'b0, 4, h);
    check("and_result", 64'(bus.result), 64'h00);
    check("and_carry",  64'(bus.carry),  64'd0);
    check("and_zero",   64'(bus.zero),   64'd1);

    // SUB r3,r0,r1 (r3 = 0xFF) ; ADD r3,r3,r1 -> 0x00 with carry
    do_reset();
    prog.delete();
    prog.push_back(enc(3, 3, 0, 1));
    prog.push_back(enc(2, 3, 3, 1));
    prog.push_back(enc(15, 0, 0, 0));
    load_prog();
    run_prog(1'b1, 1'b0, 4, h);
    check("wrap_add_result", 64'(bus.result), 64'h00);
    check("wrap_add_carry",  64'(bus.carry),  64'd1);
    check("wrap_add_zero",   64'(bus.zero),   64'd1);

    // Opcode 9 into r1, then read r1 back through OR -> r1 must still be 1
    do_reset();
    prog.delete();
    prog.push_back(enc(9, 1, 2, 3));
    prog.push_back(enc(1, 0, 1, 1));
    prog.push_back(enc(15, 0, 0, 0));
    load_prog();
    run_prog(1'b1, 1'b0, 4, h);
    check("op9_illegal", 64'(bus.illegal), 64'd1);
    check("op9_r1_kept", 64'(bus.result),  64'h01);

    // Opcode 4 r2 <- (r3 < r1), then read r2 back (2 when SLT is disabled)
    prog.delete();
    prog.push_back(enc(4, 2, 3, 1));
    prog.push_back(enc(1, 0, 2, 2));
    prog.push_back(enc(15, 0, 0, 0));
    load_prog();
    run_prog(1'b1, 1'b0, 4, h);
`ifdef MC_DATAPATH_SLT_EN
    check("op4_illegal", 64'(bus.illegal), 64'd0);
    check("op4_r2",      64'(bus.result),  64'h00);
`else
    check("op4_illegal", 64'(bus.illegal), 64'd1);
    check("op4_r2_kept", 64'(bus.result),  64'h02);
`endif

    // Next start clears illegal (checked at start inside run_prog)
    prog.delete();
    prog.push_back(enc(5, 0, 0, 0));
    prog.push_back(enc(15, 0, 0, 0));
    load_prog();
    run_prog(1'b1, 1'b0, 4, h);
    check("illegal_cleared", 64'(bus.illegal), 64'd0);

    // Sixteen NOPs: pc wraps, busy stays high, imem_we/start ignored while busy
    do_reset();
    prog.delete();
    for (int i = 0; i < IMEM_DEPTH; i++) prog.push_back(enc(5, 0, 0, 0));
    load_prog();
    run_prog(1'b1, 1'b1, IMEM_DEPTH + 4, h);
    check("nop_no_halt", 64'(h), 64'd0);
    check("nop_busy",    64'(bus.busy), 64'd1);

    // Reset during EXECUTE of ADD r2,r0,r1: aborted, no writeback
    prog.delete();
    prog.push_back(enc(2, 2, 0, 1));
    prog.push_back(enc(15, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    load_prog();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_exec_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_idle_busy", 64'(bus.busy), 64'd0);
    prog.delete();
    prog.push_back(enc(1, 3, 2, 2));
    prog.push_back(enc(15, 0, 0, 0));
    load_prog();
    run_prog(1'b1, 1'b0, 4, h);
    check("mid_r2_kept", 64'(bus.result), 64'h02);

    // Randomised programs, register state carried between runs
    do_reset();
    for (int p = 0; p < 8; p++) begin
      prog.delete();
      len = int'($urandom_range(1, 10));
      for (int i = 0; i < len; i++)
        prog.push_back(enc(int'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
      prog.push_back(enc(15, 0, 0, 0));
      load_prog();
      run_prog(1'b1, 1'b0, IMEM_DEPTH, h);
      check("rand_halted", 64'(h), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter DATA_W, default 8: register, ALU and result width; legal range 4..32.
REQ-002 Parameter REG_N, default 4: register count, power of two >= 2; RA_W = clog2(REG_N).
REQ-003 Parameter IMEM_DEPTH, default 16: instruction words, power of two; PC_W = clog2(IMEM_DEPTH); IW = 4 + 3*RA_W.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  single-cycle pulse; begins execution at pc 0.
REQ-007 imem_we  in  1  instruction-memory write enable.
REQ-008 imem_waddr  in  PC_W  instruction write address.
REQ-009 imem_wdata  in  IW  instruction word {opcode[3:0], rd, rs1, rs2}, opcode in MSBs.
REQ-010 busy  out  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.
REQ-011 done  out  1  one-cycle pulse on entry to HALT.
REQ-012 pc  out  PC_W  address of the current instruction.
REQ-013 result  out  DATA_W  last registered ALU result.
REQ-014 carry  out  1  carry/borrow flag.
REQ-015 zero  out  1  high when result == 0.
REQ-016 illegal  out  1  sticky; set on any undefined opcode.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
REQ-018 Transitions SHALL be:
- IDLE/HALT --start--> FETCH, pc = 0, illegal cleared.
- FETCH -> DECODE: latch instruction register.
- DECODE -> EXECUTE: latch operands A = reg[rs1], B = reg[rs2].
- EXECUTE -> WRITEBACK: latch result and flags.
- WRITEBACK -> FETCH: write reg[rd], pc += 1.
REQ-019 Each non-HALT instruction SHALL take exactly 4 cycles.
REQ-020 Opcode semantics SHALL be:
- 0 AND, 1 OR, 2 ADD, 3 SUB (A-B), 4 SLT (unsigned A<B, zero-extended), 5 NOP.
- 15 HALT: DECODE -> HALT; no writeback; pc holds.
REQ-021 ADD SHALL compute at DATA_W+1 bits; result takes the low DATA_W bits and carry takes bit DATA_W.
REQ-022 SUB SHALL set carry = 1 iff A < B unsigned (borrow); AND, OR and SLT SHALL clear carry.
REQ-023 NOP SHALL leave result, carry, zero and registers unchanged.
REQ-024 Undefined opcodes SHALL execute as NOP and set illegal.
REQ-025 pc SHALL wrap from IMEM_DEPTH-1 to 0 after WRITEBACK without halting.
REQ-026 imem_we SHALL be honoured only when busy is low; it SHALL be ignored while busy.
REQ-027 start while busy SHALL be ignored.
REQ-028 rd == rs1 or rd == rs2 SHALL use pre-write operand values (operands are latched in DECODE).
REQ-029 Instruction memory SHALL read combinationally; the register file SHALL write synchronously and read combinationally.

Reset
REQ-030 On reset, state SHALL be IDLE.
REQ-031 On reset: pc = 0; result = 0; carry = 0; zero = 1; illegal = 0; busy = 0; done = 0.
REQ-032 On reset, reg[i] SHALL be i (truncated to DATA_W).
REQ-033 Instruction memory SHALL be unaffected by reset.
REQ-034 Reset SHALL take priority over start and imem_we, including mid-instruction, which is aborted with no writeback.

Configuration
REQ-035 MC_DATAPATH_SLT_EN defined: opcode 4 SHALL execute SLT.
REQ-036 MC_DATAPATH_SLT_EN undefined: opcode 4 SHALL be undefined, executing as NOP and setting illegal.

Structure
REQ-037 Package mc_datapath_pkg SHALL hold:
- opcode constants: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOP, OP_HALT;
- the FSM state enum;
- the field-position function for IW.
REQ-038 The ALU SHALL be a sub-module mc_alu (parameter DATA_W): combinational, outputs result and carry.

Verification
REQ-039 Default parameters; load ADD r3,r3,r2 then HALT; start -> result 0x05, carry 0, done pulses 4 cycles after ADD enters FETCH plus the HALT fetch/decode cycles.
REQ-040 SUB r0,r0,r1 -> r0 = 0xFF, carry 1, zero 0; then AND r1,r0,r0 with r0 = 0 -> zero 1.
REQ-041 r3 = 0xFF via SUB, then ADD r3,r3,r1 -> result 0x00, carry 1, zero 1.
REQ-042 Opcode 9, and opcode 4 with MC_DATAPATH_SLT_EN undefined -> illegal 1, registers unchanged; illegal cleared by the next start.
REQ-043 Sixteen NOPs, no HALT -> pc wraps 15 -> 0, busy stays 1; imem_we and start while busy have no effect.
REQ-044 Assert reset during EXECUTE of ADD r2,... -> r2 retains 2, state IDLE next cycle, all outputs at REQ-031 values.
